// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - machine-mode trap/MRET sequencer owning the M-mode trap CSRs
module trap_controller #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic        exception_taken,
    input  logic [31:0] exception_cause,
    input  logic [31:0] exception_val,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        trap_active
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        TRAP_SAVE    = 2'd1,
        MRET_RESTORE = 2'd2,
        REDIRECT     = 2'd3
    } state_t;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    state_t      r_state, w_next_state;
    logic        r_mstatus_mie, r_mstatus_mpie;
    logic [31:0] r_mie, r_mtvec, r_mepc, r_mcause, r_mtval;
    logic [31:0] r_pend_epc, r_pend_cause, r_pend_tval, r_target;

    logic [31:0] w_mip, w_pending, w_base, w_irq_cause, w_trap_target;
    logic        w_decide, w_fire_irq, w_fire_exc, w_fire_mret, w_fire;

    assign w_mip     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
    assign w_pending = w_mip & r_mie;
    assign w_decide  = (r_state == IDLE) && instr_valid;

    assign w_fire_irq  = w_decide && r_mstatus_mie && (w_pending != 32'b0);
    assign w_fire_exc  = w_decide && !w_fire_irq && exception_taken;
    assign w_fire_mret = w_decide && !w_fire_irq && !exception_taken && mret;
    assign w_fire      = w_fire_irq || w_fire_exc || w_fire_mret;

    // Interrupt priority: external, then software, then timer
    always_comb begin
        w_irq_cause = 32'h8000_0007;
        if (w_pending[11])
            w_irq_cause = 32'h8000_000B;
        else if (w_pending[3])
            w_irq_cause = 32'h8000_0003;
    end

    assign w_base = {r_mtvec[31:2], 2'b00};

    always_comb begin
        w_trap_target = w_base;
        if (w_fire_irq && r_mtvec[0])
            w_trap_target = w_base + {25'b0, w_irq_cause[4:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_fire_irq || w_fire_exc)
                    w_next_state = TRAP_SAVE;
                else if (w_fire_mret)
                    w_next_state = MRET_RESTORE;
            end
            TRAP_SAVE:    w_next_state = REDIRECT;
            MRET_RESTORE: w_next_state = REDIRECT;
            REDIRECT: begin
                if (redirect_ready)
                    w_next_state = IDLE;
            end
            default:      w_next_state = IDLE;
        endcase
    end

    // Decision cycle latches everything the sequence needs, so later input changes are ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'b0;
            r_mtvec        <= MTVEC_RESET;
            r_mepc         <= 32'b0;
            r_mcause       <= 32'b0;
            r_mtval        <= 32'b0;
            r_pend_epc     <= 32'b0;
            r_pend_cause   <= 32'b0;
            r_pend_tval    <= 32'b0;
            r_target       <= 32'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire_irq) begin
                        r_pend_epc   <= pc & ~32'h3;
                        r_pend_cause <= w_irq_cause;
                        r_pend_tval  <= 32'b0;
                        r_target     <= w_trap_target;
                    end else if (w_fire_exc) begin
                        r_pend_epc   <= pc & ~32'h3;
                        r_pend_cause <= exception_cause;
                        r_pend_tval  <= exception_val;
                        r_target     <= w_trap_target;
                    end else if (w_fire_mret) begin
                        r_target     <= r_mepc;
                    end else if (csr_we) begin
                        case (csr_addr)
                            ADDR_MSTATUS: begin
                                r_mstatus_mie  <= csr_wdata[3];
                                r_mstatus_mpie <= csr_wdata[7];
                            end
                            ADDR_MIE:    r_mie    <= csr_wdata & 32'h0000_0888;
                            ADDR_MTVEC:  r_mtvec  <= csr_wdata & ~32'h2;
                            ADDR_MEPC:   r_mepc   <= csr_wdata & ~32'h3;
                            ADDR_MCAUSE: r_mcause <= csr_wdata;
                            ADDR_MTVAL:  r_mtval  <= csr_wdata;
                            default: ;
                        endcase
                    end
                end
                TRAP_SAVE: begin
                    r_mepc         <= r_pend_epc;
                    r_mcause       <= r_pend_cause;
                    r_mtval        <= r_pend_tval;
                    r_mstatus_mpie <= r_mstatus_mie;
                    r_mstatus_mie  <= 1'b0;
                end
                MRET_RESTORE: begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata = 32'b0;
        csr_hit   = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS: csr_rdata = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
            ADDR_MIE:     csr_rdata = r_mie;
            ADDR_MTVEC:   csr_rdata = r_mtvec;
            ADDR_MEPC:    csr_rdata = r_mepc;
            ADDR_MCAUSE:  csr_rdata = r_mcause;
            ADDR_MTVAL:   csr_rdata = r_mtval;
            ADDR_MIP:     csr_rdata = w_mip;
            default:      csr_hit   = 1'b0;
        endcase
    end

    assign trap_active    = (r_state != IDLE);
    assign stall          = w_fire || trap_active;
    assign flush          = (r_state == TRAP_SAVE) || (r_state == MRET_RESTORE);
    assign redirect_valid = (r_state == REDIRECT);
    assign redirect_pc    = redirect_valid ? r_target : 32'b0;

endmodule
